ebdown_counter: RTL

//   8-bit loadable down-counter/timer built as two cascaded 4-bit nibble stages.
//   It is the count-down counterpart of the team's 8-bit up-counter.
//   A value is loaded and then decremented on enabled cycles, with a borrow-out per nibble.
//   At terminal count it pulses done, then either halts or auto-reloads.
//   It serves as a programmable interval timer for the hw3 datapath.

---
 rtl/ebdown_counter.sv | 117 +++++++++++
 1 files changed

// File: rtl/ebdown_counter.sv
// ---------------------------------------------------------------------------
// ebdown_counter
//   8-bit loadable down-counter / interval timer made of two cascaded 4-bit
//   nibble stages. A loaded value is decremented on enabled cycles. When the
//   count reaches 0 and is clocked once more, a one-cycle done pulse is issued
//   and the block either halts at 0 or reloads the stored load value.
//
// Parameters
//   BCD     0: binary nibbles (low nibble wraps 0->F)
//           1: decimal nibbles (low nibble wraps 0->9, loads clamped to 9)
//   RELOAD  1: auto-reload at terminal count; 0: halt at 0
//
// Ports
//   clk       in   1  rising-edge clock
//   reset     in   1  asynchronous active-low reset
//   enable    in   1  count enable (only honoured in RUN)
//   load      in   1  synchronous load strobe, priority over enable
//   load_val  in   8  value captured on load ({high nibble, low nibble})
//   out       out  4  low nibble of the count
//   outh      out  4  high nibble of the count
//   ebout     out  8  {outh, out}
//   bco       out  2  [0] low-nibble borrow, [1] full 8-bit borrow
//   done      out  1  registered one-cycle terminal-count pulse
//   busy      out  1  high while in RUN
// ---------------------------------------------------------------------------
module ebdown_counter #(
    parameter bit BCD    = 1'b0,
    parameter bit RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] out,
    output logic [3:0] outh,
    output logic [7:0] ebout,
    output logic [1:0] bco,
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Value the low nibble takes when it borrows from the high nibble.
    localparam logic [3:0] NIB_MAX = BCD ? 4'd9 : 4'hF;

    state_t     state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic [7:0] rld, rld_nx;
    logic       done_nx;
    logic [7:0] load_fix;

    // Loaded nibbles above 9 are forced to 9 in decimal mode so the count
    // never holds a non-decimal digit.
    function automatic logic [3:0] fix_nib(input logic [3:0] n);
        if (BCD && (n > 4'd9)) return 4'd9;
        return n;
    endfunction

    assign load_fix = {fix_nib(load_val[7:4]), fix_nib(load_val[3:0])};

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rld_nx   = rld;
        done_nx  = 1'b0;
        if (load) begin
            cnt_nx   = load_fix;
            rld_nx   = load_fix;
            state_nx = RUN;
        end else if (state == RUN && enable) begin
            if (cnt == 8'h00) begin
                // Terminal count: pulse done next cycle, then reload or stop.
                done_nx = 1'b1;
                if (RELOAD) cnt_nx   = rld;
                else        state_nx = HALT;
            end else if (cnt[3:0] == 4'h0) begin
                // Low nibble borrows; high nibble is non-zero here.
                cnt_nx = {cnt[7:4] - 4'd1, NIB_MAX};
            end else begin
                cnt_nx[3:0] = cnt[3:0] - 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values sampled at the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 8'h00;
            rld   <= 8'h00;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            rld   <= rld_nx;
            done  <= done_nx;
        end
    end

    assign ebout  = cnt;
    assign out    = cnt[3:0];
    assign outh   = cnt[7:4];
    assign busy   = (state == RUN);
    // Reset forces IDLE, so both borrows are low while reset is held.
    assign bco[0] = (state == RUN) & enable & (cnt[3:0] == 4'h0);
    assign bco[1] = bco[0] & (cnt[7:4] == 4'h0);

endmodule
